key_search_collector: RTL

- Downstream stage of the parallel RC4 decryption cores. Each core sweeps its own slice of the 24-bit key space.
- Watches every core's finish and exhausted flags. Selects the winning core and latches its secret key.
- Broadcasts outer_finish back to all cores so they stop.
- Reports a global failure when every core has swept its range without a match.

---
 rtl/key_search_pkg.sv | 21 ++
 rtl/key_search_collector_lowest_set_encoder.sv | 29 ++
 rtl/key_search_collector.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/key_search_pkg.sv
`default_nettype none
// ============================================================================
// Module  : key_search_pkg
// Brief   : Shared state encoding and default sizing for the key-search
//           collector and its helpers.
// Rev     : 1.0
// ============================================================================
package key_search_pkg;

    localparam int c_NUM_CORES = 6;
    localparam int c_KEY_W     = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FOUND  = 2'd2,
        FAILED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/key_search_collector_lowest_set_encoder.sv
`default_nettype none
// ============================================================================
// Module  : lowest_set_encoder
// Brief   : Combinational priority encoder returning the lowest set bit index
//           of a request vector plus an any-set flag.
// Rev     : 1.0
// ============================================================================
module lowest_set_encoder #(
    parameter int NUM_CORES  = 6,
    parameter int CORE_IDX_W = 3
) (
    input  logic [NUM_CORES-1:0]  vec,
    output logic                  any_set,
    output logic [CORE_IDX_W-1:0] index
);

    always_comb begin
        any_set = |vec;
        index   = '0;
        // Scan from the top down so the lowest set bit is written last and wins.
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = CORE_IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_search_collector.sv
`default_nettype none
// ============================================================================
// Module  : key_search_collector
// Brief   : Collects finish/exhausted flags from parallel RC4 key-search cores,
//           latches the winning key and broadcasts a stop. Optional elapsed
//           cycle counter enabled by KEY_SEARCH_TIMER_EN.
// Rev     : 1.0
// ============================================================================
module key_search_collector
    import key_search_pkg::*;
#(
    parameter int NUM_CORES  = c_NUM_CORES,
    parameter int KEY_W      = c_KEY_W,
    localparam int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       core_finish,
    input  logic [NUM_CORES-1:0]       core_exhausted,
    input  logic [NUM_CORES*KEY_W-1:0] core_key,
    output logic                       outer_finish,
    output logic                       busy,
    output logic                       key_valid,
    output logic [KEY_W-1:0]           found_key,
    output logic [CORE_IDX_W-1:0]      found_core,
`ifdef KEY_SEARCH_TIMER_EN
    output logic [31:0]                elapsed_cycles,
`endif
    output logic                       search_failed
);

    state_t                r_state,        w_state_nxt;
    logic [NUM_CORES-1:0]  r_exh_mask,     w_exh_mask_nxt;
    logic                  r_outer_finish, w_outer_finish_nxt;
    logic                  r_busy,         w_busy_nxt;
    logic                  r_key_valid,    w_key_valid_nxt;
    logic [KEY_W-1:0]      r_found_key,    w_found_key_nxt;
    logic [CORE_IDX_W-1:0] r_found_core,   w_found_core_nxt;
    logic                  r_failed,       w_failed_nxt;

    logic                  w_any_finish;
    logic [CORE_IDX_W-1:0] w_win_idx;
    logic [NUM_CORES-1:0]  w_exh_all;
    logic [KEY_W-1:0]      w_keys [NUM_CORES];

    generate
        for (genvar g = 0; g < NUM_CORES; g++) begin : g_key_unpack
            assign w_keys[g] = core_key[g*KEY_W +: KEY_W];
        end
    endgenerate

    lowest_set_encoder #(
        .NUM_CORES  (NUM_CORES),
        .CORE_IDX_W (CORE_IDX_W)
    ) u_finish_enc (
        .vec     (core_finish),
        .any_set (w_any_finish),
        .index   (w_win_idx)
    );

    assign w_exh_all = r_exh_mask | core_exhausted;

    always_comb begin
        w_state_nxt        = r_state;
        w_exh_mask_nxt     = r_exh_mask;
        w_outer_finish_nxt = r_outer_finish;
        w_key_valid_nxt    = r_key_valid;
        w_found_key_nxt    = r_found_key;
        w_found_core_nxt   = r_found_core;
        w_failed_nxt       = r_failed;
        case (r_state)
            SEARCH: begin
                w_exh_mask_nxt = w_exh_all;
                // A finishing core beats exhaustion even if this cycle completes the mask.
                if (w_any_finish) begin
                    w_found_key_nxt    = w_keys[w_win_idx];
                    w_found_core_nxt   = w_win_idx;
                    w_key_valid_nxt    = 1'b1;
                    w_outer_finish_nxt = 1'b1;
                    w_state_nxt        = FOUND;
                end else if (&w_exh_all) begin
                    w_failed_nxt       = 1'b1;
                    w_outer_finish_nxt = 1'b1;
                    w_state_nxt        = FAILED;
                end
            end
            default: begin
                if (start) begin
                    w_state_nxt        = SEARCH;
                    w_exh_mask_nxt     = '0;
                    w_outer_finish_nxt = 1'b0;
                    w_key_valid_nxt    = 1'b0;
                    w_found_key_nxt    = '0;
                    w_found_core_nxt   = '0;
                    w_failed_nxt       = 1'b0;
                end
            end
        endcase
        w_busy_nxt = (w_state_nxt == SEARCH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_exh_mask     <= '0;
            r_outer_finish <= 1'b0;
            r_busy         <= 1'b0;
            r_key_valid    <= 1'b0;
            r_found_key    <= '0;
            r_found_core   <= '0;
            r_failed       <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_exh_mask     <= w_exh_mask_nxt;
            r_outer_finish <= w_outer_finish_nxt;
            r_busy         <= w_busy_nxt;
            r_key_valid    <= w_key_valid_nxt;
            r_found_key    <= w_found_key_nxt;
            r_found_core   <= w_found_core_nxt;
            r_failed       <= w_failed_nxt;
        end
    end

`ifdef KEY_SEARCH_TIMER_EN
    logic [31:0] r_elapsed;

    // Counts SEARCH cycles, including the cycle that decides the outcome.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_elapsed <= '0;
        end else if (r_state == SEARCH) begin
            if (r_elapsed != 32'hFFFF_FFFF) begin
                r_elapsed <= r_elapsed + 32'd1;
            end
        end else if (start) begin
            r_elapsed <= '0;
        end
    end

    assign elapsed_cycles = r_elapsed;
`endif

    assign outer_finish  = r_outer_finish;
    assign busy          = r_busy;
    assign key_valid     = r_key_valid;
    assign found_key     = r_found_key;
    assign found_core    = r_found_core;
    assign search_failed = r_failed;

endmodule
`default_nettype wire
